wb_ram_slave: RTL and testbench
===============================

Name: wb_ram_slave

Overview:
Wishbone classic responder: single-port word-organised RAM behind the core's Wishbone bus; target of the core's bus-initiator bridge. Accepts byte/half/word cycles with low-aligned byte selects; applies the lane shift from the byte address; returns a one-cycle ack after a programmable number of wait states. Used as boot/scratch memory and as the bench's reference bus target.

Parameters:
WB_DATA_WIDTH, 32, bus data width; only 32 supported.
WB_ADDR_WIDTH, 32, bus byte-address width.
WB_SEL_WIDTH, WB_DATA_WIDTH/8, byte-select width.
MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
WAIT_STATES, 0, extra cycles between request accept and ack; 0..15.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_n_i  in  1  reset, asynchronous, active-low.
wb_cyc_i  in  1  bus cycle valid.
wb_stb_i  in  1  strobe.
wb_we_i  in  1  1 = write.
wb_sel_i  in  WB_SEL_WIDTH  low-aligned select: 0001 byte, 0011 half, 1111 word.
wb_addr_i  in  WB_ADDR_WIDTH  byte address.
wb_data_i  in  WB_DATA_WIDTH  write data, right-aligned.
wb_data_o  out  WB_DATA_WIDTH  read data, right-aligned, registered.
wb_ack_o  out  1  one-cycle ack pulse.
wb_err_o  out  1  error pulse (see Optional Feature).

Behaviour:
- Reset (rst_n_i low, any time, incl. mid-cycle): state IDLE, wb_ack_o=0, wb_err_o=0, wb_data_o=0, wait counter=0, captured request cleared. RAM contents not reset. Pending write dropped.
- FSM: IDLE, WAIT, RESP, DONE.
- IDLE: at edge with cyc&stb: capture addr, we, sel, data; counter=WAIT_STATES; go WAIT if WAIT_STATES>0 else RESP.
- WAIT: decrement counter each cycle; counter==1 -> RESP. cyc low in WAIT -> abort: IDLE, no write, no ack.
- Entry to RESP (registered): perform access, drive wb_ack_o=1 (or wb_err_o) for exactly one cycle, then DONE. Latency: ack high WAIT_STATES+1 cycles after the edge that sampled the request.
- DONE: hold ack=0; return to IDLE only when stb or cyc sampled low. Stb held high after ack never gets a second ack.
- Decode: off=addr[1:0]; idx=addr[2 +: log2(MEM_WORDS)]. Bad access = (sel==0011 and off[0]=1) or (sel==1111 and off!=0) or addr >= 4*MEM_WORDS or sel not in {0001,0011,1111}.
- Write (good): lane mask = sel<<off; data = wb_data_i<<(8*off); only masked bytes of mem[idx] updated.
- Read (good): wb_data_o = (mem[idx]>>(8*off)) with bytes outside sel forced to 0 (byte: [31:8]=0; half: [31:16]=0). wb_data_o holds until the next read response.
- Bad access: no RAM write; wb_data_o=0 on reads; still acked (see Optional Feature).
- Write response: wb_data_o unchanged.
- Requests arriving while not IDLE are ignored (bus is single-initiator; no pipelining).

Optional Feature:
WB_RAM_MISALIGN_ERR_EN. Defined: bad access responds with one-cycle wb_err_o=1 and wb_ack_o=0, same timing as ack; DONE entered normally. Undefined: wb_err_o tied 0; bad access acked as above (write dropped, read returns 0).

Test Plan:
- Word write addr 0x10 data 0xDEADBEEF sel 1111, then word read 0x10 -> ack one cycle each, read data 0xDEADBEEF; WAIT_STATES=0 ack 1 cycle after accept.
- Byte write 0xAA to 0x13 sel 0001 over 0x11223344 at 0x10 -> word read 0x10 = 0xAA223344; byte read 0x13 = 0x000000AA; half read 0x12 = 0x0000AA22.
- WAIT_STATES=3: read -> ack exactly 4 cycles after accept edge; stb held high 5 further cycles after ack -> no second ack, FSM stays DONE until stb low.
- Half write to 0x11 (misaligned) data 0x5555 -> no RAM change; macro off: ack=1, err=0; macro on: err=1, ack=0.
- Read addr 4*MEM_WORDS -> data 0, ack (or err with macro); WAIT_STATES=3, drop cyc after 1 wait cycle -> no ack, no write, next request served normally.
- Assert rst_n_i low mid-WAIT of a write to 0x20 -> ack/err/data 0 immediately; mem[0x20] unchanged; post-reset read served with normal latency.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM responder: byte/half/word access with lane shift and WAIT_STATES wait states.
// Define WB_RAM_MISALIGN_ERR_EN to answer bad accesses with wb_err_o instead of wb_ack_o.
module wb_ram_slave #(
   parameter int WB_DATA_WIDTH = 32,
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
   parameter int MEM_WORDS     = 1024,
   parameter int WAIT_STATES   = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   input  logic                     wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
   input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
   output logic [WB_DATA_WIDTH-1:0] wb_data_o,
   output logic                     wb_ack_o,
   output logic                     wb_err_o,
   output logic [1:0]               dbg_state
);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [WB_ADDR_WIDTH:0] ADDR_LIMIT = (WB_ADDR_WIDTH + 1)'(MEM_WORDS) << 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                     we_q, we_d;
   logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
   logic [WB_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                     ack_q, ack_d;
   logic                     bad, mem_we;
   logic [1:0]               off;
   logic [IDX_W-1:0]         idx;
   logic [WB_SEL_WIDTH-1:0]  lane_mask;
   logic [WB_DATA_WIDTH-1:0] wdata_sh, rdata_sh, sel_mask;
   logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

   // Decode of the captured request; only consulted while in RESP.
   assign off       = addr_q[1:0];
   assign idx       = addr_q[2 +: IDX_W];
   assign bad       = ((sel_q == 4'b0011) && off[0]) ||
                      ((sel_q == 4'b1111) && (off != 2'd0)) ||
                      ({1'b0, addr_q} >= ADDR_LIMIT) ||
                      !((sel_q == 4'b0001) || (sel_q == 4'b0011) || (sel_q == 4'b1111));
   assign lane_mask = sel_q << off;
   assign wdata_sh  = wdata_q << {off, 3'b000};
   assign rdata_sh  = mem[idx] >> {off, 3'b000};
   assign sel_mask  = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};

`ifdef WB_RAM_MISALIGN_ERR_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
`ifdef WB_RAM_MISALIGN_ERR_EN
      err_d   = 1'b0;
`endif
      mem_we  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               addr_d  = wb_addr_i;
               we_d    = wb_we_i;
               sel_d   = wb_sel_i;
               wdata_d = wb_data_i;
               cnt_d   = 4'(WAIT_STATES);
               state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (!wb_cyc_i) begin
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end else if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_DONE;
            mem_we  = we_q && !bad;
            if (!we_q) rdata_d = bad ? '0 : (rdata_sh & sel_mask);
`ifdef WB_RAM_MISALIGN_ERR_EN
            ack_d = !bad;
            err_d = bad;
`else
            ack_d = 1'b1;
`endif
         end
         S_DONE: begin
            // Initiator must drop stb or cyc before another request can start.
            if (!wb_cyc_i || !wb_stb_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
      end
   end

`ifdef WB_RAM_MISALIGN_ERR_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) err_q <= 1'b0;
      else          err_q <= err_d;
   end
   assign wb_err_o = err_q;
`else
   assign wb_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < WB_SEL_WIDTH; b++) begin
            if (lane_mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign wb_data_o = rdata_q;
   assign wb_ack_o  = ack_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave: one instance with no wait states, one with three.
module tb_wb_ram_slave;
`ifdef WB_RAM_MISALIGN_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic        dsel = 1'b0;

   logic [31:0] data0, data3, rdata;
   logic        ack0, ack3, err0, err3, ack, err;
   logic [1:0]  st0, st3, st;

   int n_tests = 0;
   int n_fail  = 0;

   int          x_lat, x_extra;
   logic        x_ack, x_err, x_timeout, x_done_ok;
   logic [31:0] x_data;
   logic [1:0]  x_st_end;

   always #5 clk_i = ~clk_i;

   wb_ram_slave #(.WAIT_STATES(0)) u_dut0 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .wb_cyc_i(cyc & ~dsel), .wb_stb_i(stb),
      .wb_we_i(we), .wb_sel_i(sel), .wb_addr_i(addr), .wb_data_i(wdata),
      .wb_data_o(data0), .wb_ack_o(ack0), .wb_err_o(err0), .dbg_state(st0));

   wb_ram_slave #(.WAIT_STATES(3)) u_dut3 (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .wb_cyc_i(cyc & dsel), .wb_stb_i(stb),
      .wb_we_i(we), .wb_sel_i(sel), .wb_addr_i(addr), .wb_data_i(wdata),
      .wb_data_o(data3), .wb_ack_o(ack3), .wb_err_o(err3), .dbg_state(st3));

   assign rdata = dsel ? data3 : data0;
   assign ack   = dsel ? ack3 : ack0;
   assign err   = dsel ? err3 : err0;
   assign st    = dsel ? st3 : st0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bus cycle; stb stays high for 'hold' cycles after the response.
   task automatic wb_xfer(input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, input int hold);
      int lat;
      @(posedge clk_i); #1;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; wdata = d;
      @(posedge clk_i);
      lat = 0;
      x_timeout = 1'b0;
      forever begin
         @(negedge clk_i);
         if (ack || err) break;
         if (lat >= 40) begin
            x_timeout = 1'b1;
            break;
         end
         @(posedge clk_i);
         lat++;
      end
      x_lat = lat; x_ack = ack; x_err = err; x_data = rdata;
      x_extra = 0; x_done_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i); @(negedge clk_i);
         if (ack || err) x_extra++;
         if (st != 2'd3) x_done_ok = 1'b0;
      end
      @(posedge clk_i); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk_i);
      if (ack || err) x_extra++;
      @(posedge clk_i); @(negedge clk_i);
      x_st_end = st;
   endtask

   task automatic check_resp(input string tag, input logic bad, input int exp_lat);
      check({tag, "/timeout"}, {31'd0, x_timeout}, 32'd0);
      check({tag, "/ack"}, {31'd0, x_ack}, {31'd0, !(bad && ERR_EN)});
      check({tag, "/err"}, {31'd0, x_err}, {31'd0, bad && ERR_EN});
      check({tag, "/lat"}, 32'(x_lat), 32'(exp_lat));
      check({tag, "/extra"}, 32'(x_extra), 32'd0);
      check({tag, "/idle"}, {30'd0, x_st_end}, 32'd0);
   endtask

   task automatic wr(input string tag, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic bad, input int exp_lat);
      wb_xfer(1'b1, s, a, d, 0);
      check_resp(tag, bad, exp_lat);
   endtask

   task automatic rd(input string tag, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] exp, input logic bad, input int exp_lat);
      wb_xfer(1'b0, s, a, 32'd0, 0);
      check_resp(tag, bad, exp_lat);
      check({tag, "/data"}, x_data, exp);
   endtask

   initial begin
      int n_ack;
      // Reset state of both instances
      #12;
      check("rst_ack0", {31'd0, ack0}, 32'd0);
      check("rst_err0", {31'd0, err0}, 32'd0);
      check("rst_data0", data0, 32'd0);
      check("rst_st0", {30'd0, st0}, 32'd0);
      check("rst_ack3", {31'd0, ack3}, 32'd0);
      check("rst_data3", data3, 32'd0);
      check("rst_st3", {30'd0, st3}, 32'd0);
      @(posedge clk_i); #3 rst_n_i = 1'b1;

      // No wait states
      dsel = 1'b0;
      wr("w_word10", 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 1);
      rd("r_word10", 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0, 1);
      wr("w_word10b", 4'b1111, 32'h10, 32'h11223344, 1'b0, 1);
      check("wr_keeps_data", x_data, 32'hDEADBEEF);
      wr("w_byte13", 4'b0001, 32'h13, 32'h000000AA, 1'b0, 1);
      rd("r_word10b", 4'b1111, 32'h10, 32'hAA223344, 1'b0, 1);
      rd("r_byte13", 4'b0001, 32'h13, 32'h000000AA, 1'b0, 1);
      rd("r_half12", 4'b0011, 32'h12, 32'h0000AA22, 1'b0, 1);
      rd("r_byte10", 4'b0001, 32'h10, 32'h00000044, 1'b0, 1);
      rd("r_half10", 4'b0011, 32'h10, 32'h00003344, 1'b0, 1);
      wr("w_half11_bad", 4'b0011, 32'h11, 32'h00005555, 1'b1, 1);
      rd("r_after_bad", 4'b1111, 32'h10, 32'hAA223344, 1'b0, 1);
      wr("w_word14", 4'b1111, 32'h14, 32'h00000000, 1'b0, 1);
      wr("w_half16", 4'b0011, 32'h16, 32'h0000BEEF, 1'b0, 1);
      rd("r_word14", 4'b1111, 32'h14, 32'hBEEF0000, 1'b0, 1);
      wr("w_word00", 4'b1111, 32'h0, 32'h12345678, 1'b0, 1);
      wr("w_oor_bad", 4'b1111, 32'h1000, 32'hCAFEF00D, 1'b1, 1);
      rd("r_word00", 4'b1111, 32'h0, 32'h12345678, 1'b0, 1);
      rd("r_oor_bad", 4'b1111, 32'h1000, 32'h00000000, 1'b1, 1);
      rd("r_word00b", 4'b1111, 32'h0, 32'h12345678, 1'b0, 1);
      rd("r_sel7_bad", 4'b0111, 32'h0, 32'h00000000, 1'b1, 1);
      rd("r_word_mis", 4'b1111, 32'h2, 32'h00000000, 1'b1, 1);

      // Three wait states
      dsel = 1'b1;
      wr("w3_word40", 4'b1111, 32'h40, 32'h0A0B0C0D, 1'b0, 4);
      wb_xfer(1'b0, 4'b1111, 32'h40, 32'd0, 5);
      check_resp("r3_hold", 1'b0, 4);
      check("r3_hold/data", x_data, 32'h0A0B0C0D);
      check("r3_hold/done", {31'd0, x_done_ok}, 32'd1);

      // Abort after one wait cycle
      @(posedge clk_i); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b1111; addr = 32'h40; wdata = 32'hFFFFFFFF;
      @(posedge clk_i);
      @(posedge clk_i); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      n_ack = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         if (ack3 || err3) n_ack++;
      end
      check("abort/no_ack", 32'(n_ack), 32'd0);
      check("abort/idle", {30'd0, st3}, 32'd0);
      rd("r3_after_abort", 4'b1111, 32'h40, 32'h0A0B0C0D, 1'b0, 4);

      // Reset in the middle of a waiting write
      wr("w3_word20", 4'b1111, 32'h20, 32'h01020304, 1'b0, 4);
      rd("r3_word40", 4'b1111, 32'h40, 32'h0A0B0C0D, 1'b0, 4);
      @(posedge clk_i); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b1111; addr = 32'h20; wdata = 32'hFFFFFFFF;
      @(posedge clk_i);
      @(posedge clk_i); #1;
      rst_n_i = 1'b0;
      #1;
      check("mid_rst/ack", {31'd0, ack3}, 32'd0);
      check("mid_rst/err", {31'd0, err3}, 32'd0);
      check("mid_rst/data", data3, 32'd0);
      check("mid_rst/st", {30'd0, st3}, 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk_i); #3 rst_n_i = 1'b1;
      rd("r3_after_rst", 4'b1111, 32'h20, 32'h01020304, 1'b0, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
